sw_btn_in: RTL and testbench
============================

# sw_btn_in

Memory-mapped input peripheral: the CPU-side reader for the board's 24 DIP switches and 5 push buttons, the read-direction counterpart of the LED output register on the same peripheral bus. Synchronizes and debounces every input bit and latches button-press events until software clears them. The read data path is combinational on the address, so the single-cycle core gets data in the same cycle as the load address. Sits on the peripheral bus next to the LED and seven-segment blocks.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 500000: clock cycles between debounce sample ticks (20 ms at 25 MHz); minimum 2.
- ADDR_SW, default 32'hFFFF_F070: switch-level register, read-only.
- ADDR_BTN, default 32'hFFFF_F078: button-level register, read-only.
- ADDR_EVT, default 32'hFFFF_F07C: button-event register, read / write-1-to-clear.

Ports:
- clk_to_led, input, 1: system clock; every flop is rising-edge.
- rst_to_led, input, 1: asynchronous, active-high reset.
- addr_to_sw, input, 32: bus address, used for both read and write.
- rdata_from_sw, output, 32: combinational read data.
- we_to_sw, input, 1: bus write enable.
- wdata_to_sw, input, 32: bus write data.
- switch, input, 24: raw switch pins, asynchronous to the clock.
- button, input, 5: raw button pins, active-high, asynchronous to the clock.

## Operation

- **Synchronizer:** each of the 29 input bits passes through a 2-flop synchronizer (sync).
- **Tick counter:**
  - Width is clog2(DEBOUNCE_CYCLES) bits.
  - Counts 0 to DEBOUNCE_CYCLES-1, then wraps to 0.
  - tick = (cnt == DEBOUNCE_CYCLES-1).
- **Sampling:** on each edge where tick=1, every bit shifts its sync value into a 3-entry history: hist <= {hist[1:0], sync}.
- **Debounce rule:** on the same tick edge, the debounced bit takes its next value from {hist[1:0], sync}:
  - all three 1 -> db <= 1.
  - all three 0 -> db <= 0.
  - otherwise -> db holds.
  - Switches produce sw_db[23:0]; buttons produce btn_db[4:0].
- **Edge detect:** btn_d <= btn_db every cycle. rise[i] = btn_db[i] & ~btn_d[i].
- **Event register evt[4:0]:**
  - Sets on rise[i].
  - A write with we_to_sw=1 and addr_to_sw==ADDR_EVT clears every evt[i] whose wdata_to_sw[i]=1.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit reads 1 afterwards.
  - Bits whose wdata bit is 0 are unaffected.
- **Other writes:** writes to ADDR_SW, ADDR_BTN or any other address are ignored and change no state.
- **Read mux (combinational):**
  - ADDR_SW -> {8'b0, sw_db}.
  - ADDR_BTN -> {27'b0, btn_db}.
  - ADDR_EVT -> {27'b0, evt}.
  - Any other address -> 32'h0.
  - Read has no side effects: reading ADDR_EVT does not clear it.
- **Reset values:** sync, hist, cnt, sw_db, btn_db, btn_d and evt are all 0. During reset rdata_from_sw is therefore 0 for every address.

## Timing

- Read latency is 0 cycles: rdata_from_sw follows addr_to_sw and register state within the same cycle.
- **Press-to-visible latency:** a bit held stable from cycle t becomes sync-valid at t+2. It appears in db on the third tick edge at or after t+2. Worst case is 2 + 3·DEBOUNCE_CYCLES cycles.
- **Event timing:** evt[i] is 1 one cycle after btn_db[i] rises (the edge where btn_d still holds 0). It is readable in the cycle after that edge.
- **Glitches:** a glitch shorter than 2 ticks never changes db; the three-equal-samples rule rejects it.
- **Release:** a release (1 -> 0) follows the same 3-tick rule and sets no event.
- **Wrap:** tick fires once per DEBOUNCE_CYCLES cycles with no drift. After reset, the first tick occurs on cycle DEBOUNCE_CYCLES-1.
- **Reset mid-operation:** asserting rst_to_led at any time clears every register immediately, without waiting for a clock edge. This includes pending events and partial histories. After release, debouncing restarts from all-zero history.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- **Reset:** hold rst_to_led, switch=24'hFFFFFF, button=5'h1F. Read ADDR_SW, ADDR_BTN and ADDR_EVT -> each returns 32'h0. After release, read ADDR_SW within 14 cycles -> returns 32'h00FFFFFF.
- **Switch debounce:** switch=24'hA5A5A5 held stable -> ADDR_SW reads 32'h00A5A5A5 no later than 14 cycles after the change. A 1-cycle pulse on switch[0] -> sw_db[0] never changes.
- **Button event:** press button[2] and hold, then release -> ADDR_BTN reads 32'h4 while held. ADDR_EVT reads 32'h4 and stays 32'h4 after release and after repeated reads.
- **Write-1-to-clear:** evt=5'h05. Write wdata=32'h1 to ADDR_EVT -> reads 32'h4. Write 32'h0 -> still 32'h4. Write 32'h4 to ADDR_SW -> no change.
- **Simultaneous set/clear:** arrange for button[1] to rise in the same cycle as a write of 32'h2 to ADDR_EVT -> evt[1]=1 afterwards.
- **Unmapped and reset mid-debounce:** read address 32'hFFFF_F074 -> returns 32'h0. Assert reset after 2 of the 3 agreeing samples -> after release, a full 3 new ticks are needed before db changes.

Source files
------------

// File: rtl/sw_btn_in.sv
// Memory-mapped reader for 24 DIP switches and 5 push buttons: each input is
// synchronized and debounced, and button presses latch write-1-to-clear events.
module sw_btn_in #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] ADDR_SW         = 32'hFFFF_F070,
    parameter logic [31:0] ADDR_BTN        = 32'hFFFF_F078,
    parameter logic [31:0] ADDR_EVT        = 32'hFFFF_F07C
) (
    input  logic        clk_to_led,
    input  logic        rst_to_led,
    input  logic [31:0] addr_to_sw,
    output logic [31:0] rdata_from_sw,
    input  logic        we_to_sw,
    input  logic [31:0] wdata_to_sw,
    input  logic [23:0] switch,
    input  logic [4:0]  button
);

    localparam int unsigned NBITS = 29;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // A bit changes only when two history samples and the current sync value agree.
    function automatic logic [NBITS-1:0] debounce_next(
        input logic [NBITS-1:0] hist1,
        input logic [NBITS-1:0] hist0,
        input logic [NBITS-1:0] sync,
        input logic [NBITS-1:0] db
    );
        logic [NBITS-1:0] all_one;
        logic [NBITS-1:0] all_zero;
        all_one  = hist1 & hist0 & sync;
        all_zero = ~(hist1 | hist0 | sync);
        return all_one | (db & ~all_zero);
    endfunction

    logic [NBITS-1:0] r_meta;
    logic [NBITS-1:0] r_sync;
    logic [NBITS-1:0] r_hist0;
    logic [NBITS-1:0] r_hist1;
    logic [NBITS-1:0] r_db;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_btn_d;
    logic [4:0]       r_evt;

    logic [NBITS-1:0] w_raw;
    logic             w_tick;
    logic [23:0]      w_sw_db;
    logic [4:0]       w_btn_db;
    logic [4:0]       w_rise;
    logic [4:0]       w_clr;
    logic             w_evt_wr;
    logic             w_unused_wdata;

    assign w_raw          = {button, switch};
    assign w_tick         = (r_cnt == CNT_LAST);
    assign w_sw_db        = r_db[23:0];
    assign w_btn_db       = r_db[28:24];
    assign w_rise         = w_btn_db & ~r_btn_d;
    assign w_evt_wr       = we_to_sw && (addr_to_sw == ADDR_EVT);
    assign w_clr          = w_evt_wr ? wdata_to_sw[4:0] : 5'b0;
    assign w_unused_wdata = ^wdata_to_sw[31:5];

    always_ff @(posedge clk_to_led or posedge rst_to_led) begin
        if (rst_to_led) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge clk_to_led or posedge rst_to_led) begin
        if (rst_to_led) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Only the two newest history entries feed the decision, so the oldest is not stored.
    always_ff @(posedge clk_to_led or posedge rst_to_led) begin
        if (rst_to_led) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_db    <= '0;
        end else if (w_tick) begin
            r_hist1 <= r_hist0;
            r_hist0 <= r_sync;
            r_db    <= debounce_next(r_hist1, r_hist0, r_sync, r_db);
        end
    end

    // Set has priority over a simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge clk_to_led or posedge rst_to_led) begin
        if (rst_to_led) begin
            r_btn_d <= '0;
            r_evt   <= '0;
        end else begin
            r_btn_d <= w_btn_db;
            r_evt   <= (r_evt & ~w_clr) | w_rise;
        end
    end

    always_comb begin
        rdata_from_sw = 32'h0;
        if (addr_to_sw == ADDR_SW) begin
            rdata_from_sw = {8'h00, w_sw_db};
        end else if (addr_to_sw == ADDR_BTN) begin
            rdata_from_sw = {27'h0, w_btn_db};
        end else if (addr_to_sw == ADDR_EVT) begin
            rdata_from_sw = {27'h0, r_evt};
        end
    end

endmodule

// File: tb/tb_sw_btn_in.sv
// Directed bench for sw_btn_in: a sample-list model checked every cycle,
// plus literal read expectations at the key latency and boundary points.
module tb_sw_btn_in;

    localparam int D = 4;
    localparam logic [31:0] A_SW  = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN = 32'hFFFF_F078;
    localparam logic [31:0] A_EVT = 32'hFFFF_F07C;

    logic        clk_to_led = 1'b0;
    logic        rst_to_led = 1'b1;
    logic [31:0] addr_to_sw = 32'h0;
    logic [31:0] rdata_from_sw;
    logic        we_to_sw = 1'b0;
    logic [31:0] wdata_to_sw = 32'h0;
    logic [23:0] switch = 24'hFFFFFF;
    logic [4:0]  button = 5'h1F;

    int checks = 0;
    int errors = 0;

    sw_btn_in #(
        .DEBOUNCE_CYCLES(D),
        .ADDR_SW(A_SW),
        .ADDR_BTN(A_BTN),
        .ADDR_EVT(A_EVT)
    ) dut (
        .clk_to_led(clk_to_led),
        .rst_to_led(rst_to_led),
        .addr_to_sw(addr_to_sw),
        .rdata_from_sw(rdata_from_sw),
        .we_to_sw(we_to_sw),
        .wdata_to_sw(wdata_to_sw),
        .switch(switch),
        .button(button)
    );

    always #5 clk_to_led = ~clk_to_led;

    // Model: pins reach the logic two edges late; every D-th edge takes a sample,
    // and a bit follows the last three samples only when they all agree.
    logic [28:0] rawq[$];
    logic [28:0] smp[$];
    logic [28:0] m_db = '0;
    logic [4:0]  m_evt = '0;
    logic [4:0]  m_rise = '0;
    int          n = 0;
    logic [28:0] m_sync, m_old, sa, sb, sc;
    logic [4:0]  m_clr;

    always @(posedge clk_to_led or posedge rst_to_led) begin
        if (rst_to_led) begin
            rawq.delete();
            smp.delete();
            smp.push_back('0);
            smp.push_back('0);
            m_db   = '0;
            m_evt  = '0;
            m_rise = '0;
            n      = 0;
        end else begin
            m_sync = (rawq.size() == 2) ? rawq[0] : '0;
            m_clr  = (we_to_sw && addr_to_sw == A_EVT) ? wdata_to_sw[4:0] : 5'h0;
            m_evt  = (m_evt & ~m_clr) | m_rise;
            m_old  = m_db;
            if (n % D == D - 1) begin
                smp.push_back(m_sync);
                sa = smp[$-2];
                sb = smp[$-1];
                sc = smp[$];
                for (int i = 0; i < 29; i++) begin
                    if (sa[i] == sb[i] && sb[i] == sc[i]) m_db[i] = sc[i];
                end
                if (smp.size() > 3) void'(smp.pop_front());
            end
            m_rise = m_db[28:24] & ~m_old[28:24];
            rawq.push_back({button, switch});
            if (rawq.size() > 2) void'(rawq.pop_front());
            n++;
        end
    end

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a == A_SW)  return {8'h00, m_db[23:0]};
        if (a == A_BTN) return {27'h0, m_db[28:24]};
        if (a == A_EVT) return {27'h0, m_evt};
        return 32'h0;
    endfunction

    logic [31:0] cmp_exp;
    always @(negedge clk_to_led) begin
        cmp_exp = model_rd(addr_to_sw);
        checks++;
        if (rdata_from_sw !== cmp_exp) begin
            errors++;
            $display("FAIL cycle_read t=%0t addr=%08h got=%08h exp=%08h",
                     $time, addr_to_sw, rdata_from_sw, cmp_exp);
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk_to_led);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        addr_to_sw = a;
        #1;
        checks++;
        if (rdata_from_sw !== e) begin
            errors++;
            $display("FAIL %s addr=%08h got=%08h exp=%08h", nm, a, rdata_from_sw, e);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_to_sw  = a;
        wdata_to_sw = d;
        we_to_sw    = 1'b1;
        @(posedge clk_to_led);
        #1;
        we_to_sw    = 1'b0;
        wdata_to_sw = 32'h0;
    endtask

    int  waited;
    bit  found;

    initial begin
        // Reset with every input high: all registers read zero.
        @(posedge clk_to_led);
        #1;
        step(2);
        lit("rst_sw",  A_SW,  32'h0);
        lit("rst_btn", A_BTN, 32'h0);
        lit("rst_evt", A_EVT, 32'h0);
        step(1);
        rst_to_led = 1'b0;
        step(11);
        lit("post_rst_sw_early", A_SW, 32'h0);
        step(1);
        lit("post_rst_sw",  A_SW,  32'h00FFFFFF);
        lit("post_rst_btn", A_BTN, 32'h0000001F);
        lit("post_rst_evt_pending", A_EVT, 32'h0);
        step(1);
        lit("post_rst_evt", A_EVT, 32'h0000001F);

        // Switch pattern, released buttons, and a rejected one-cycle glitch.
        wr(A_EVT, 32'h1F);
        lit("evt_cleared", A_EVT, 32'h0);
        switch = 24'hA5A5A5;
        button = 5'h0;
        step(14);
        lit("sw_a5",       A_SW,  32'h00A5A5A5);
        lit("btn_release", A_BTN, 32'h0);
        lit("release_no_evt", A_EVT, 32'h0);
        switch = 24'hA5A5A4;
        step(1);
        switch = 24'hA5A5A5;
        step(14);
        lit("sw_glitch", A_SW, 32'h00A5A5A5);

        // Press and release button 2; the event persists across reads.
        button = 5'h04;
        step(15);
        lit("btn2_held", A_BTN, 32'h4);
        lit("evt2_set",  A_EVT, 32'h4);
        button = 5'h0;
        step(15);
        lit("btn2_released", A_BTN, 32'h0);
        lit("evt2_kept",     A_EVT, 32'h4);
        lit("evt2_reread",   A_EVT, 32'h4);

        // Write-1-to-clear behaviour.
        button = 5'h05;
        step(15);
        lit("evt05", A_EVT, 32'h5);
        wr(A_EVT, 32'h1);
        lit("w1c_bit0", A_EVT, 32'h4);
        wr(A_EVT, 32'h0);
        lit("w0_nochange", A_EVT, 32'h4);
        wr(A_SW, 32'h4);
        lit("wr_sw_ignored", A_EVT, 32'h4);
        lit("sw_unchanged",  A_SW,  32'h00A5A5A5);
        button = 5'h0;
        step(15);

        // Clear on the exact cycle button 1 sets its event: the set survives.
        wr(A_EVT, 32'h1F);
        lit("evt_all_clear", A_EVT, 32'h0);
        button = 5'h02;
        waited = 0;
        found  = 1'b0;
        while (!found && waited < 40) begin
            @(posedge clk_to_led);
            #1;
            waited++;
            if (m_db[25]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL btn1_rise_wait got=timeout exp=rise within 40 cycles");
        end
        addr_to_sw  = A_EVT;
        wdata_to_sw = 32'h2;
        we_to_sw    = 1'b1;
        step(1);
        we_to_sw    = 1'b0;
        wdata_to_sw = 32'h0;
        lit("set_beats_clear", A_EVT, 32'h2);

        // Unmapped addresses.
        lit("unmapped_f074", 32'hFFFF_F074, 32'h0);
        lit("unmapped_zero", 32'h0000_0000, 32'h0);
        step(1);

        // Reset after two agreeing samples discards the partial history.
        switch = 24'h0;
        button = 5'h0;
        rst_to_led = 1'b1;
        step(2);
        step(1);
        rst_to_led = 1'b0;
        switch = 24'hFFFFFF;
        step(8);
        rst_to_led = 1'b1;
        step(1);
        lit("mid_rst_sw",  A_SW,  32'h0);
        lit("mid_rst_evt", A_EVT, 32'h0);
        step(1);
        rst_to_led = 1'b0;
        step(11);
        lit("mid_rst_restart_early", A_SW, 32'h0);
        step(1);
        lit("mid_rst_restart", A_SW, 32'h00FFFFFF);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
